// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB write-back and decode read-port bundle for wb_regfile
//
// Signals:
//   ALUResultIn, ReadDataDMIn, MemToReg, RegWrite, WriteRegister : MEM/WB beat (into regfile)
//   ReadRegister1, ReadRegister2                                 : decode read addresses (into regfile)
//   ReadData1, ReadData2                                         : decode read data (out of regfile)
//   WriteData                                                    : selected write-back value (out of regfile)
//   WbCount                                                      : committed write count (out of regfile)
// Modports: slave = register file side, master = pipeline side.
interface wb_regfile_if;
    logic [31:0] ALUResultIn;
    logic [31:0] ReadDataDMIn;
    logic        MemToReg;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData;
    logic [31:0] WbCount;

    modport slave (
        input  ALUResultIn, ReadDataDMIn, MemToReg, RegWrite, WriteRegister,
        input  ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, WriteData, WbCount
    );

    modport master (
        output ALUResultIn, ReadDataDMIn, MemToReg, RegWrite, WriteRegister,
        output ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, WriteData, WbCount
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MIPS write-back mux and 32x32 architectural register file
//
// Parameters:
//   BYPASS : 1 = a read of the register being committed this cycle returns WriteData
//            0 = reads return stored contents only
// Ports:
//   clk : pipeline clock, rising edge
//   rst : asynchronous active-high reset, clears r1..r31 and WbCount
//   bus : wb_regfile_if.slave (MEM/WB beat in; read data, WriteData, WbCount out)
module wb_regfile #(
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    // r0 is hardwired to zero, so only r1..r31 hold state.
    logic [31:0] regs [1:31];
    logic [31:0] wb_count;
    logic [31:0] write_data;
    logic        commit;

    assign write_data = bus.MemToReg ? bus.ReadDataDMIn : bus.ALUResultIn;
    assign commit     = bus.RegWrite && (bus.WriteRegister != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            wb_count <= 32'd0;
        end else if (commit) begin
            regs[bus.WriteRegister] <= write_data;
            wb_count                <= wb_count + 32'd1;
        end
    end

    // Address 0 wins over the bypass so r0 reads zero even while a
    // discarded write to r0 is on the bus.
    function automatic logic [31:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0) begin
            return 32'd0;
        end else if (BYPASS && commit && (bus.WriteRegister == addr)) begin
            return write_data;
        end else begin
            return regs[addr];
        end
    endfunction

    always_comb begin
        bus.ReadData1 = read_port(bus.ReadRegister1);
        bus.ReadData2 = read_port(bus.ReadRegister2);
    end

    assign bus.WriteData = write_data;
    assign bus.WbCount   = wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile, bypass and no-bypass builds side by side
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] alu;
    logic [31:0] dm;
    logic        m2r;
    logic        rw;
    logic [4:0]  wr;
    logic [4:0]  rr1;
    logic [4:0]  rr2;

    int tests;
    int fails;

    wb_regfile_if bus_b ();
    wb_regfile_if bus_n ();

    assign bus_b.ALUResultIn   = alu;
    assign bus_b.ReadDataDMIn  = dm;
    assign bus_b.MemToReg      = m2r;
    assign bus_b.RegWrite      = rw;
    assign bus_b.WriteRegister = wr;
    assign bus_b.ReadRegister1 = rr1;
    assign bus_b.ReadRegister2 = rr2;
    assign bus_n.ALUResultIn   = alu;
    assign bus_n.ReadDataDMIn  = dm;
    assign bus_n.MemToReg      = m2r;
    assign bus_n.RegWrite      = rw;
    assign bus_n.WriteRegister = wr;
    assign bus_n.ReadRegister1 = rr1;
    assign bus_n.ReadRegister2 = rr2;

    wb_regfile #(.BYPASS(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
    wb_regfile #(.BYPASS(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] dm;
        logic        m2r;
        logic        rw;
        logic [4:0]  wr;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] exp_wd;
        logic [31:0] exp_b1;
        logic [31:0] exp_b2;
        logic [31:0] exp_n1;
        logic [31:0] exp_n2;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vec [8];

    logic [31:0] mregs [32];
    logic [31:0] mcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic m,
                         input logic w, input logic [4:0] wa,
                         input logic [4:0] r1, input logic [4:0] r2);
        alu = a; dm = d; m2r = m; rw = w; wr = wa; rr1 = r1; rr2 = r2;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] addr, input bit byp,
                                               input logic [31:0] wd, input bit cm,
                                               input logic [4:0] wa);
        if (addr == 0) return 32'd0;
        if (byp && cm && wa == addr) return wd;
        return mregs[addr];
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Row fields: alu, dm, m2r, rw, wr, rr1, rr2, wd, byp rd1/rd2, nobyp rd1/rd2, count after edge
        vec[0] = '{32'h0000_00AA, 32'h0,         1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 32'hAA,        32'hAA,        32'h0,         32'h0,        32'h0,         32'd1};
        vec[1] = '{32'h0,         32'hDEADBEEF,  1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 32'hDEADBEEF,  32'hDEADBEEF,  32'hDEADBEEF,  32'hAA,       32'hAA,        32'd2};
        vec[2] = '{32'hFFFFFFFF,  32'h0,         1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'hFFFFFFFF,  32'h0,         32'hDEADBEEF,  32'h0,        32'hDEADBEEF,  32'd2};
        vec[3] = '{32'h55,        32'h0,         1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 32'h55,        32'h0,         32'h0,         32'h0,        32'h0,         32'd2};
        vec[4] = '{32'h11,        32'h0,         1'b0, 1'b1, 5'd3, 5'd3, 5'd9, 32'h11,        32'h11,        32'h0,         32'h0,        32'h0,         32'd3};
        vec[5] = '{32'h22,        32'h0,         1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h22,        32'h22,        32'h22,        32'h11,       32'h11,        32'd4};
        vec[6] = '{32'h22,        32'h33,        1'b1, 1'b0, 5'd3, 5'd3, 5'd7, 32'h33,        32'h22,        32'hDEADBEEF,  32'h22,       32'hDEADBEEF,  32'd4};
        vec[7] = '{32'h0,         32'h0,         1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 32'h0,         32'h0,         32'h22,        32'h0,        32'h22,        32'd4};

        // Reset state
        rst = 1'b1;
        #1;
        check("reset_cnt_b", bus_b.WbCount, 32'd0);
        check("reset_cnt_n", bus_n.WbCount, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            drive(vec[i].alu, vec[i].dm, vec[i].m2r, vec[i].rw, vec[i].wr, vec[i].rr1, vec[i].rr2);
            #1;
            check($sformatf("vec%0d_wd", i),  bus_b.WriteData, vec[i].exp_wd);
            check($sformatf("vec%0d_b1", i),  bus_b.ReadData1, vec[i].exp_b1);
            check($sformatf("vec%0d_b2", i),  bus_b.ReadData2, vec[i].exp_b2);
            check($sformatf("vec%0d_n1", i),  bus_n.ReadData1, vec[i].exp_n1);
            check($sformatf("vec%0d_n2", i),  bus_n.ReadData2, vec[i].exp_n2);
            @(negedge clk);
            check($sformatf("vec%0d_cntb", i), bus_b.WbCount, vec[i].exp_cnt);
            check($sformatf("vec%0d_cntn", i), bus_n.WbCount, vec[i].exp_cnt);
        end
        // After the final edge the no-bypass build sees r3 = 0x22 too
        drive(0, 0, 0, 0, 0, 5'd3, 5'd3);
        #1;
        check("nobyp_after_edge1", bus_n.ReadData1, 32'h22);
        check("nobyp_after_edge2", bus_n.ReadData2, 32'h22);

        // Async reset mid-cycle, with a pending commit that must be discarded
        @(negedge clk);
        drive(32'h12345678, 0, 0, 1, 5'd5, 5'd5, 5'd0);
        @(negedge clk);
        drive(32'h99, 0, 0, 1, 5'd6, 5'd5, 5'd6);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_rd1_b", bus_b.ReadData1, 32'd0);
        check("rst_async_rd1_n", bus_n.ReadData1, 32'd0);
        check("rst_async_cnt",   bus_b.WbCount,   32'd0);
        @(negedge clk);
        check("rst_held_r6",  bus_n.ReadData2, 32'd0);
        check("rst_held_cnt", bus_n.WbCount,   32'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 5'd5, 5'd5, 5'd6);
        repeat (3) @(negedge clk);
        check("post_rst_cnt_b", bus_b.WbCount, 32'd0);
        check("post_rst_cnt_n", bus_n.WbCount, 32'd0);
        check("post_rst_r5",    bus_n.ReadData1, 32'd0);

        // Randomized run against the architectural model; DUTs start from reset
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcnt = 32'd0;
        for (int c = 0; c < 400; c++) begin
            logic [31:0] wd;
            bit          cm;
            drive($urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31) < 24 ? $urandom_range(0, 7) : $urandom_range(0, 31)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            if (c % 5 == 0) rr2 = wr;
            #1;
            wd = m2r ? dm : alu;
            cm = rw && (wr != 0);
            check("rnd_wd", bus_b.WriteData, wd);
            check("rnd_b1", bus_b.ReadData1, model_read(rr1, 1, wd, cm, wr));
            check("rnd_b2", bus_b.ReadData2, model_read(rr2, 1, wd, cm, wr));
            check("rnd_n1", bus_n.ReadData1, model_read(rr1, 0, wd, cm, wr));
            check("rnd_n2", bus_n.ReadData2, model_read(rr2, 0, wd, cm, wr));
            @(negedge clk);
            if (cm) begin
                mregs[wr] = wd;
                mcnt = mcnt + 1;
            end
            check("rnd_cnt_b", bus_b.WbCount, mcnt);
            check("rnd_cnt_n", bus_n.WbCount, mcnt);
        end

        // Counter wrap via deposit into the count register
        drive(0, 0, 0, 0, 5'd1, 5'd1, 5'd0);
        force dut_b.wb_count = 32'hFFFFFFFF;
        force dut_n.wb_count = 32'hFFFFFFFF;
        #1;
        release dut_b.wb_count;
        release dut_n.wb_count;
        @(negedge clk);
        check("wrap_pre_b", bus_b.WbCount, 32'hFFFFFFFF);
        check("wrap_pre_n", bus_n.WbCount, 32'hFFFFFFFF);
        drive(32'h0000CAFE, 0, 0, 1, 5'd1, 5'd1, 5'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 5'd1, 5'd0);
        #1;
        check("wrap_cnt_b", bus_b.WbCount,   32'd0);
        check("wrap_cnt_n", bus_n.WbCount,   32'd0);
        check("wrap_r1_b",  bus_b.ReadData1, 32'h0000CAFE);
        check("wrap_r1_n",  bus_n.ReadData1, 32'h0000CAFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs and selects the write-back value: the loaded word when MemToReg is 1, the ALU result when it is 0. Commits that value to a 32×32 register file and serves the two decode-stage read ports. A configurable internal write-through bypass lets a decode-stage read of a register see the value being written in the same cycle.

## Interface
- BYPASS, 1 — 1: same-cycle write-to-read forwarding enabled; 0: reads return stored contents only.
- clk  input  1  — pipeline clock; all state updates on rising edge.
- rst  input  1  — asynchronous, active-high reset.
- ALUResultIn  input  32  — ALU result from MEM/WB.
- ReadDataDMIn  input  32  — data-memory read data from MEM/WB.
- MemToReg  input  1  — 1 selects ReadDataDMIn, 0 selects ALUResultIn.
- RegWrite  input  1  — write enable from MEM/WB.
- WriteRegister  input  5  — destination register number.
- ReadRegister1  input  5  — decode read address, port 1 (rs).
- ReadRegister2  input  5  — decode read address, port 2 (rt).
- ReadData1  output  32  — port 1 read data, combinational.
- ReadData2  output  32  — port 2 read data, combinational.
- WriteData  output  32  — selected write-back value, combinational; feeds the EX forwarding unit.
- WbCount  output  32  — count of committed register writes, registered.

## Operation
- WriteData = MemToReg ? ReadDataDMIn : ALUResultIn, always, regardless of RegWrite.
- Commit condition: RegWrite=1 and WriteRegister≠0. On a rising clk edge with the commit condition true, regs[WriteRegister] ← WriteData and WbCount ← WbCount+1.
- Register 0 is hardwired to zero:
  - writes to it are discarded and do not increment WbCount;
  - reads of address 0 return 0 on both ports, including under bypass.
- Read port N:
  - if ReadRegisterN=0: returns 0;
  - else if BYPASS=1 and the commit condition holds and WriteRegister=ReadRegisterN: returns WriteData;
  - otherwise returns regs[ReadRegisterN].
- Both ports may read the same register; both may hit the bypass simultaneously.
- WbCount is a 32-bit unsigned counter that wraps from 0xFFFFFFFF to 0x00000000 without a flag.
- Register 0 is not implemented as storage; no unused state is held.

## Timing
- Reset (rst=1, asynchronous):
  - all 31 registers clear to 0 immediately, independent of clk;
  - WbCount = 0;
  - ReadData1/2 therefore read 0;
  - WriteData remains combinational from its inputs.
- While rst=1, rising edges perform no write and no count.
- Reset asserted mid-operation discards any write on that edge.
- First write is possible on the first rising edge after rst deasserts.
- Write latency:
  - the value is visible in regs after the rising edge;
  - with BYPASS=1 it is visible on ReadDataN in the same cycle, before the edge;
  - with BYPASS=0 it becomes visible one cycle later, and the hazard unit must stall one extra cycle.
- Read latency: zero cycles (combinational from ReadRegisterN and register state).
- No handshake. Every cycle is a valid MEM/WB beat, and bubbles arrive as RegWrite=0.

## Test plan
- Reset clear: write 0x12345678 to r5, assert rst asynchronously mid-cycle → ReadData1 (addr 5) = 0 before next edge, WbCount = 0; deassert, no write for 3 cycles → WbCount stays 0.
- Mux + commit: MemToReg=0, ALUResultIn=0x0000_00AA, RegWrite=1, WriteRegister=7 → WriteData=0xAA; after the edge r7=0xAA, WbCount=1. Then MemToReg=1, ReadDataDMIn=0xDEADBEEF to r7 → r7=0xDEADBEEF, WbCount=2.
- r0 hardwire: RegWrite=1, WriteRegister=0, WriteData=0xFFFFFFFF → ReadData1 (addr 0)=0 before and after the edge, WbCount unchanged; RegWrite=0 to r9 with data 0x55 → r9 unchanged.
- Bypass, BYPASS=1: r3=0x11, present a write of 0x22 to r3 with ReadRegister1=ReadRegister2=3 → both ports read 0x22 in the same cycle; with RegWrite=0 they read 0x11.
- No bypass, BYPASS=0: same stimulus → both ports read 0x11 before the edge and 0x22 after it.
- Counter wrap: force WbCount to 0xFFFFFFFF (hierarchical deposit), commit one write to r1 → WbCount=0x00000000, r1 written correctly.
